input_port_unit: RTL and testbench
==================================

# input_port_unit

Per-input-port front end of the mesh router; one instance per input (R, L, U, D, EJ/inject). Buffers incoming flits in a small FIFO and computes the XY route of each head flit. Presents the resulting 3-bit output-port request and its pending flag to the port allocator. After a grant, streams the packet to the crossbar and pulses a finish strobe when the tail flit leaves, which releases the allocated output.

## Interface
- `FLIT_W`, default 16: flit width. Bits [FLIT_W-1:FLIT_W-2] are the flit type; head flits carry dest X at [7:4] and dest Y at [3:0].
- `DEPTH`, default 4: FIFO depth, power of two ≥ 2.
- `COORD_W`, default 4: coordinate width.
- `CUR_X`, default 0: this router's X coordinate.
- `CUR_Y`, default 0: this router's Y coordinate.

Ports (reset is synchronous, active-high; one clock):
- `clk`  in  1  clock.
- `reset`  in  1  synchronous reset, active-high.
- `in_flit`  in  FLIT_W  flit from the upstream link.
- `in_valid`  in  1  `in_flit` is valid.
- `in_ready`  out  1  FIFO can accept a flit (`!full`).
- `req`  out  3  requested output port: 000 R, 001 L, 010 U, 011 D, 100 EJ.
- `req_pending`  out  1  `req` is valid and not yet granted. This is the allocator's per-input "request unassigned" signal.
- `grant`  in  1  allocator has assigned the requested output to this input; held until release.
- `done`  out  1  one-cycle pulse: tail flit has departed. This is the allocator's per-port finish signal.
- `flit_out`  out  FLIT_W  FIFO head flit to the crossbar.
- `flit_out_valid`  out  1  `flit_out` is transferable.
- `flit_out_ready`  in  1  crossbar/downstream accepts the flit.
- `err`  out  1  sticky flag: a non-head flit arrived at the FIFO front in IDLE.

## Operation
- Flit types: 01 head, 00 body, 10 tail, 11 head+tail (single-flit packet).
- Push occurs when `in_valid & in_ready`. No push when full, even if a pop happens the same cycle.
- Pop occurs when `flit_out_valid & flit_out_ready`, or on an IDLE discard.
- XY route, computed from the front flit: dx>CUR_X → R; dx<CUR_X → L; else dy>CUR_Y → U; dy<CUR_Y → D; else EJ. Comparisons are unsigned on COORD_W bits.
- FSM states: IDLE, WAIT_GRANT, ACTIVE.
  - IDLE, FIFO non-empty, front type is head or head+tail: register the route into `req`, go to WAIT_GRANT.
  - IDLE, FIFO non-empty, front type is body or tail: pop and discard it, set `err`, stay in IDLE.
  - WAIT_GRANT: `req_pending`=1. When `grant`=1 is sampled, go to ACTIVE.
  - ACTIVE: `flit_out_valid` = `!empty & grant`. When the popped flit is tail or head+tail, go to IDLE and raise `done` for the next cycle.
  - ACTIVE with `grant` low: stall, with no pop and no state change.
- `req` holds its value from WAIT_GRANT entry until the next route is computed. It is stable throughout ACTIVE.
- `flit_out` always equals the FIFO front, whatever the state.

## Timing
- Reset values: FIFO empty, state IDLE, `in_ready`=1, `req`=000, `req_pending`=0, `done`=0, `flit_out_valid`=0, `err`=0. `flit_out` is don't-care but is driven as 0.
- Reset mid-packet discards all buffered flits and drops the request. No `done` is issued.
- Latency:
  - Head pushed at edge N is at the front after N.
  - `req_pending`=1 after edge N+1.
  - `grant` sampled high at edge M gives `flit_out_valid` after M.
  - One flit transfers per cycle while `flit_out_ready`=1.
- Tail popped at edge T: `done`=1 during cycle T..T+1 only. State is IDLE after T. The next head can raise `req_pending` after T+1 at the earliest.
- FIFO pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
- Full: `in_ready`=0. Empty in ACTIVE: `flit_out_valid`=0 and the unit waits in ACTIVE.

## Structure
- Shared `noc_pkg`:
  - port codes (R/L/U/D/EJ = 0..4);
  - flit type codes;
  - header field positions;
  - FSM state encoding.
- Sub-module `flit_fifo` (synchronous FIFO: push/pop/full/empty/front, single clock, sync reset). The FSM and routing stay in `input_port_unit`.

## Test plan
- CUR=(1,1). Push head dest (3,1), body, tail; hold `grant`=1 from the cycle after `req_pending`, `flit_out_ready`=1. Expect `req`=000 and `req_pending` one cycle after the head reaches the front. Expect 3 flits out in 3 consecutive cycles, then a single-cycle `done`.
- Route coverage with head+tail flits to (0,1), (1,2), (1,0), (1,1). Expect `req` = 001, 010, 011, 100. Expect `done` after each single pop.
- Fill the FIFO with `flit_out_ready`=0 and `grant`=1. Expect `in_ready`=0 at DEPTH entries and the 5th push refused. Release ready: expect FIFO order preserved across pointer wrap.
- Body flit arrives first in IDLE. Expect it discarded, `err`=1 sticky, no `req_pending`. A following head is routed normally.
- Drop `grant` mid-packet for 2 cycles. Expect `flit_out_valid`=0 and no pops. Expect transfer to resume and `done` on the tail.
- Assert `reset` while in ACTIVE with 2 flits buffered. Expect all outputs at their reset values next cycle, and FIFO empty.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: output port codes, flit type codes,
// head-flit field positions, input-port FSM states and flit type helpers.
package noc_pkg;

  localparam logic [2:0] PORT_R  = 3'd0;
  localparam logic [2:0] PORT_L  = 3'd1;
  localparam logic [2:0] PORT_U  = 3'd2;
  localparam logic [2:0] PORT_D  = 3'd3;
  localparam logic [2:0] PORT_EJ = 3'd4;

  localparam logic [1:0] FT_BODY     = 2'b00;
  localparam logic [1:0] FT_HEAD     = 2'b01;
  localparam logic [1:0] FT_TAIL     = 2'b10;
  localparam logic [1:0] FT_HEADTAIL = 2'b11;

  localparam int HDR_DX_LSB = 4;
  localparam int HDR_DY_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_GRANT = 2'd1,
    ST_ACTIVE     = 2'd2
  } state_t;

  function automatic logic is_head(input logic [1:0] ft);
    return (ft == FT_HEAD) || (ft == FT_HEADTAIL);
  endfunction

  function automatic logic is_tail(input logic [1:0] ft);
    return (ft == FT_TAIL) || (ft == FT_HEADTAIL);
  endfunction

endpackage

// File: rtl/input_port_unit_if.sv
// Link, allocator and crossbar signals of one router input port.
interface input_port_unit_if #(
  parameter int FLIT_W = 16
);
  logic [FLIT_W-1:0] in_flit;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        req;
  logic              req_pending;
  logic              grant;
  logic              done;
  logic [FLIT_W-1:0] flit_out;
  logic              flit_out_valid;
  logic              flit_out_ready;
  logic              err;

  modport master (
    output in_flit, in_valid, grant, flit_out_ready,
    input  in_ready, req, req_pending, done, flit_out, flit_out_valid, err
  );

  modport slave (
    input  in_flit, in_valid, grant, flit_out_ready,
    output in_ready, req, req_pending, done, flit_out, flit_out_valid, err
  );
endinterface

// File: rtl/flit_fifo.sv
// Single-clock flit FIFO with synchronous reset; front word reads as zero when empty.
module flit_fifo #(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [FLIT_W-1:0] din,
  input  logic              pop,
  output logic [FLIT_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [FLIT_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    count_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= din;
  end

  assign full  = (count_r == CNT_FULL);
  assign empty = (count_r == '0);
  assign dout  = empty ? '0 : mem_r[rd_ptr_r];
endmodule

// File: rtl/input_port_unit.sv
// Mesh router input port: buffers flits, XY-routes each head flit, requests an
// output from the allocator and streams the granted packet to the crossbar.
module input_port_unit
  import noc_pkg::*;
#(
  parameter int FLIT_W  = 16,
  parameter int DEPTH   = 4,
  parameter int COORD_W = 4,
  parameter int CUR_X   = 0,
  parameter int CUR_Y   = 0
) (
  input logic               clk,
  input logic               reset,
  input_port_unit_if.slave  bus
);
  localparam logic [COORD_W-1:0] CX = COORD_W'(CUR_X);
  localparam logic [COORD_W-1:0] CY = COORD_W'(CUR_Y);

  state_t             state_r;
  state_t             state_next_s;
  logic [FLIT_W-1:0]  front_s;
  logic [1:0]         front_type_s;
  logic [COORD_W-1:0] dx_s;
  logic [COORD_W-1:0] dy_s;
  logic [2:0]         route_s;
  logic               full_s;
  logic               empty_s;
  logic               push_s;
  logic               pop_s;
  logic               out_valid_s;
  logic               pending_s;
  logic               discard_s;
  logic [2:0]         req_r;
  logic               done_r;
  logic               err_r;

  assign push_s       = bus.in_valid & ~full_s;
  assign front_type_s = front_s[FLIT_W-1 -: 2];
  assign dx_s         = front_s[HDR_DX_LSB +: COORD_W];
  assign dy_s         = front_s[HDR_DY_LSB +: COORD_W];
  assign discard_s    = (state_r == ST_IDLE) & ~empty_s &
                        ((front_type_s == FT_BODY) || (front_type_s == FT_TAIL));

  flit_fifo #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .din   (bus.in_flit),
    .pop   (pop_s),
    .dout  (front_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // X first, then Y; equal coordinates eject locally.
  always_comb begin
    if (dx_s > CX)      route_s = PORT_R;
    else if (dx_s < CX) route_s = PORT_L;
    else if (dy_s > CY) route_s = PORT_U;
    else if (dy_s < CY) route_s = PORT_D;
    else                route_s = PORT_EJ;
  end

  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_next_s;
  end

  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s && is_head(front_type_s)) state_next_s = ST_WAIT_GRANT;
        else                                    state_next_s = ST_IDLE;
      end
      ST_WAIT_GRANT: begin
        if (bus.grant) state_next_s = ST_ACTIVE;
        else           state_next_s = ST_WAIT_GRANT;
      end
      ST_ACTIVE: begin
        if (pop_s && is_tail(front_type_s)) state_next_s = ST_IDLE;
        else                                state_next_s = ST_ACTIVE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid_s = 1'b0;
    pending_s   = 1'b0;
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE:       pop_s = discard_s;
      ST_WAIT_GRANT: pending_s = 1'b1;
      ST_ACTIVE: begin
        out_valid_s = ~empty_s & bus.grant;
        pop_s       = out_valid_s & bus.flit_out_ready;
      end
      default: begin
        out_valid_s = 1'b0;
        pending_s   = 1'b0;
        pop_s       = 1'b0;
      end
    endcase
  end

  // req is captured once per packet and held until the next head is routed.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_r  <= 3'd0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      if ((state_r == ST_IDLE) && !empty_s && is_head(front_type_s)) req_r <= route_s;
      done_r <= (state_r == ST_ACTIVE) & pop_s & is_tail(front_type_s);
      if (discard_s) err_r <= 1'b1;
    end
  end

  assign bus.in_ready       = ~full_s;
  assign bus.req            = req_r;
  assign bus.req_pending    = pending_s;
  assign bus.done           = done_r;
  assign bus.flit_out       = front_s;
  assign bus.flit_out_valid = out_valid_s;
  assign bus.err            = err_r;
endmodule

// File: tb/tb_input_port_unit.sv
// Directed bench for input_port_unit at router (1,1): queue-based packet model
// checked every cycle, plus hand-computed expectations per scenario.
module tb_input_port_unit;
  localparam int DEPTH = 4;
  localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_HT = 2'b11;

  logic clk;
  logic reset;
  input_port_unit_if #(.FLIT_W(16)) bus ();

  input_port_unit #(.FLIT_W(16), .DEPTH(DEPTH), .COORD_W(4), .CUR_X(1), .CUR_Y(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  bit en      = 1'b0;
  logic [15:0] out_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [1:0] t, input logic [5:0] pl,
                                     input logic [3:0] x, input logic [3:0] y);
    return {t, pl, x, y};
  endfunction

  // Behavioural model: packet phase 0 idle, 1 requesting, 2 streaming.
  logic [15:0] q[$];
  int          phase  = 0;
  logic [2:0]  m_req  = 3'd0;
  logic        m_err  = 1'b0;
  logic        m_done = 1'b0;

  function automatic logic [2:0] xy_port(input logic [15:0] f);
    int dx, dy;
    dx = int'(f[7:4]);
    dy = int'(f[3:0]);
    if (dx > 1) return 3'd0;
    if (dx < 1) return 3'd1;
    if (dy > 1) return 3'd2;
    if (dy < 1) return 3'd3;
    return 3'd4;
  endfunction

  always @(posedge clk) begin
    logic [15:0] f;
    logic [1:0]  t;
    bit          do_push, do_pop, fin;
    if (reset) begin
      q.delete();
      phase = 0; m_req = 3'd0; m_err = 1'b0; m_done = 1'b0;
    end else begin
      do_push = bus.in_valid && (q.size() < DEPTH);
      do_pop  = 1'b0;
      fin     = 1'b0;
      f = (q.size() > 0) ? q[0] : 16'h0;
      t = f[15:14];
      if (phase == 0 && q.size() > 0) begin
        if (t == T_HEAD || t == T_HT) begin m_req = xy_port(f); phase = 1; end
        else begin do_pop = 1'b1; m_err = 1'b1; end
      end else if (phase == 1) begin
        if (bus.grant) phase = 2;
      end else if (phase == 2) begin
        if (q.size() > 0 && bus.grant && bus.flit_out_ready) begin
          do_pop = 1'b1;
          if (t == T_TAIL || t == T_HT) begin fin = 1'b1; phase = 0; end
        end
      end
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(bus.in_flit);
      m_done = fin;
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("m_in_ready", {31'd0, bus.in_ready}, {31'd0, q.size() < DEPTH});
      chk("m_req_pending", {31'd0, bus.req_pending}, {31'd0, phase == 1});
      chk("m_req", {29'd0, bus.req}, {29'd0, m_req});
      chk("m_done", {31'd0, bus.done}, {31'd0, m_done});
      chk("m_err", {31'd0, bus.err}, {31'd0, m_err});
      chk("m_fov", {31'd0, bus.flit_out_valid},
          {31'd0, (phase == 2) && (q.size() > 0) && bus.grant});
      if (q.size() > 0) chk("m_flit_out", {16'd0, bus.flit_out}, {16'd0, q[0]});
      if (bus.flit_out_valid === 1'b1 && bus.flit_out_ready) out_log.push_back(bus.flit_out);
      if (bus.done === 1'b1) n_done++;
    end
  end

  task automatic wait_sig(input string nm, input int which, input int bound);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < bound && !hit; i++) begin
      case (which)
        0:       hit = (bus.req_pending === 1'b1);
        default: hit = (bus.done === 1'b1);
      endcase
      if (!hit) @(negedge clk);
    end
    chk(nm, {31'd0, hit}, 32'd1);
  endtask

  task automatic push1(input logic [15:0] f);
    bus.in_valid = 1'b1;
    bus.in_flit  = f;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    chk({tag, "_req"}, {29'd0, bus.req}, 32'd0);
    chk({tag, "_req_pending"}, {31'd0, bus.req_pending}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_fov"}, {31'd0, bus.flit_out_valid}, 32'd0);
    chk({tag, "_err"}, {31'd0, bus.err}, 32'd0);
    chk({tag, "_flit_out"}, {16'd0, bus.flit_out}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] h, b0, b1, tl;
    logic [15:0] fl[5];
    logic [3:0]  dxs[4], dys[4];
    logic [2:0]  exp_req[4];
    int d0;
    bit ok;

    bus.in_valid = 1'b0; bus.in_flit = 16'h0; bus.grant = 1'b0;
    bus.flit_out_ready = 1'b1; reset = 1'b1;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);

    // 1: three-flit packet to (3,1) goes right
    h = mk(T_HEAD, 6'h01, 4'd3, 4'd1); b0 = mk(T_BODY, 6'h2A, 4'hB, 4'hC); tl = mk(T_TAIL, 6'h15, 4'h5, 4'h6);
    out_log.delete(); d0 = n_done;
    bus.in_valid = 1'b1; bus.in_flit = h;
    @(negedge clk);
    chk("t1_rp_early", {31'd0, bus.req_pending}, 32'd0);
    bus.in_flit = b0;
    @(negedge clk);
    chk("t1_rp", {31'd0, bus.req_pending}, 32'd1);
    chk("t1_req", {29'd0, bus.req}, 32'd0);
    bus.grant = 1'b1; bus.in_flit = tl;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t1_fov0", {31'd0, bus.flit_out_valid}, 32'd1);
    chk("t1_flit0", {16'd0, bus.flit_out}, {16'd0, h});
    @(negedge clk);
    chk("t1_flit1", {16'd0, bus.flit_out}, {16'd0, b0});
    @(negedge clk);
    chk("t1_flit2", {16'd0, bus.flit_out}, {16'd0, tl});
    chk("t1_fov2", {31'd0, bus.flit_out_valid}, 32'd1);
    @(negedge clk);
    chk("t1_done", {31'd0, bus.done}, 32'd1);
    chk("t1_fov_after", {31'd0, bus.flit_out_valid}, 32'd0);
    @(negedge clk);
    chk("t1_done_clear", {31'd0, bus.done}, 32'd0);
    chk("t1_nflits", out_log.size(), 32'd3);
    chk("t1_ndone", n_done - d0, 32'd1);
    bus.grant = 1'b0;

    // 2: single-flit packets cover L, U, D, EJ
    dxs = '{4'd0, 4'd1, 4'd1, 4'd1}; dys = '{4'd1, 4'd2, 4'd0, 4'd1};
    exp_req = '{3'b001, 3'b010, 3'b011, 3'b100};
    for (int i = 0; i < 4; i++) begin
      d0 = n_done;
      push1(mk(T_HT, 6'(i), dxs[i], dys[i]));
      wait_sig("t2_rp_timeout", 0, 10);
      chk("t2_req", {29'd0, bus.req}, {29'd0, exp_req[i]});
      bus.grant = 1'b1;
      wait_sig("t2_done_timeout", 1, 10);
      @(negedge clk);
      bus.grant = 1'b0;
      chk("t2_ndone", n_done - d0, 32'd1);
    end

    // 3: fill to DEPTH with the crossbar stalled, then drain across the wrap
    fl[0] = mk(T_HEAD, 6'h3, 4'd3, 4'd1);
    fl[1] = mk(T_BODY, 6'h11, 4'h1, 4'h2);
    fl[2] = mk(T_BODY, 6'h22, 4'h3, 4'h4);
    fl[3] = mk(T_BODY, 6'h33, 4'h5, 4'h6);
    fl[4] = mk(T_TAIL, 6'h3F, 4'h7, 4'h8);
    out_log.delete(); d0 = n_done;
    bus.grant = 1'b1; bus.flit_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_flit = fl[i];
      @(negedge clk);
    end
    chk("t3_full", {31'd0, bus.in_ready}, 32'd0);
    bus.in_flit = fl[4];
    @(negedge clk);
    chk("t3_refused", {31'd0, bus.in_ready}, 32'd0);
    bus.flit_out_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
    end
    chk("t3_space_timeout", {31'd0, ok}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_sig("t3_done_timeout", 1, 20);
    @(negedge clk);
    bus.grant = 1'b0;
    chk("t3_nflits", out_log.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < out_log.size()) chk("t3_order", {16'd0, out_log[i]}, {16'd0, fl[i]});
    chk("t3_ndone", n_done - d0, 32'd1);

    // 4: stray body flit in IDLE is discarded and flagged
    chk("t4_err_pre", {31'd0, bus.err}, 32'd0);
    push1(mk(T_BODY, 6'h15, 4'd3, 4'd1));
    chk("t4_err_early", {31'd0, bus.err}, 32'd0);
    @(negedge clk);
    chk("t4_err", {31'd0, bus.err}, 32'd1);
    chk("t4_rp", {31'd0, bus.req_pending}, 32'd0);
    @(negedge clk);
    chk("t4_rp_late", {31'd0, bus.req_pending}, 32'd0);
    push1(mk(T_HT, 6'h2, 4'd2, 4'd1));
    wait_sig("t4_rp_timeout", 0, 10);
    chk("t4_req", {29'd0, bus.req}, 32'd0);
    bus.grant = 1'b1;
    wait_sig("t4_done_timeout", 1, 10);
    @(negedge clk);
    bus.grant = 1'b0;
    chk("t4_err_sticky", {31'd0, bus.err}, 32'd1);

    // 5: grant withdrawn for two cycles mid-packet
    h = mk(T_HEAD, 6'h5, 4'd1, 4'd2); b0 = mk(T_BODY, 6'h0A, 4'hA, 4'hA);
    b1 = mk(T_BODY, 6'h0B, 4'hB, 4'hB); tl = mk(T_TAIL, 6'h0C, 4'hC, 4'hC);
    out_log.delete(); d0 = n_done;
    push1(h); push1(b0); push1(b1); push1(tl);
    wait_sig("t5_rp_timeout", 0, 10);
    chk("t5_req", {29'd0, bus.req}, 32'd2);
    bus.grant = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.grant = 1'b0;
    @(negedge clk);
    chk("t5_stall_fov0", {31'd0, bus.flit_out_valid}, 32'd0);
    chk("t5_stall_front0", {16'd0, bus.flit_out}, {16'd0, b0});
    @(negedge clk);
    chk("t5_stall_fov1", {31'd0, bus.flit_out_valid}, 32'd0);
    chk("t5_stall_front1", {16'd0, bus.flit_out}, {16'd0, b0});
    bus.grant = 1'b1;
    wait_sig("t5_done_timeout", 1, 10);
    @(negedge clk);
    bus.grant = 1'b0;
    chk("t5_nflits", out_log.size(), 32'd4);
    if (out_log.size() == 4) begin
      chk("t5_f0", {16'd0, out_log[0]}, {16'd0, h});
      chk("t5_f1", {16'd0, out_log[1]}, {16'd0, b0});
      chk("t5_f2", {16'd0, out_log[2]}, {16'd0, b1});
      chk("t5_f3", {16'd0, out_log[3]}, {16'd0, tl});
    end
    chk("t5_ndone", n_done - d0, 32'd1);

    // 6: reset while ACTIVE with two flits buffered
    bus.flit_out_ready = 1'b0;
    push1(mk(T_HEAD, 6'h6, 4'd0, 4'd0));
    push1(mk(T_BODY, 6'h7, 4'h7, 4'h7));
    wait_sig("t6_rp_timeout", 0, 10);
    chk("t6_req", {29'd0, bus.req}, 32'd1);
    bus.grant = 1'b1;
    @(negedge clk);
    chk("t6_active_fov", {31'd0, bus.flit_out_valid}, 32'd1);
    d0 = n_done;
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("t6_rst");
    reset = 1'b0; bus.grant = 1'b0; bus.flit_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_empty_rp", {31'd0, bus.req_pending}, 32'd0);
      chk("t6_empty_ready", {31'd0, bus.in_ready}, 32'd1);
    end
    chk("t6_no_done", n_done - d0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
